// File: rtl/count_seq_ctrl.sv
// count_seq_ctrl: start/pause/clear sequencer for a 4-bit up/down counter with a
// prescaled count tick and an active-low 7-segment decode of the count.
//
// Build option: CNT_AUTORELOAD_EN
//   defined   - terminal event reloads the count, stays in RUN, done_o pulses one cycle
//   undefined - terminal event enters DONE; done_o is high while in DONE
//
// Ports:
//   clk_i      system clock
//   rst_i      synchronous active-high reset
//   start_n_i  start/resume pushbutton, active-low, asynchronous
//   stop_n_i   pause pushbutton, active-low, asynchronous
//   clr_n_i    clear pushbutton, active-low, asynchronous
//   dir_i      1 = count up, 0 = count down
//   limit_i    terminal value
//   count_o    current counter value
//   hex_o      segments {g,f,e,d,c,b,a}, active-low
//   running_o  high in RUN (registered)
//   done_o     terminal indication (registered)
module count_seq_ctrl #(
    parameter int unsigned PRESCALE = 50_000_000
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       start_n_i,
    input  logic       stop_n_i,
    input  logic       clr_n_i,
    input  logic       dir_i,
    input  logic [3:0] limit_i,
    output logic [3:0] count_o,
    output logic [6:0] hex_o,
    output logic       running_o,
    output logic       done_o
);

    localparam logic [25:0] PresMax = 26'(PRESCALE - 1);

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StRun   = 2'd1;
    localparam logic [1:0] StPause = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    // Button bit order: {clr, stop, start}
    logic [2:0]  sync1_q, sync2_q, prev_q;
    logic [2:0]  evt;
    logic        ev_start, ev_stop, ev_clr;

    logic [1:0]  state_q, state_d;
    logic [3:0]  count_q, count_d;
    logic [25:0] presc_q, presc_d;
    logic        running_q, running_d;
    logic        done_q, done_d;

    logic        tick;
    logic        at_term;
    logic [3:0]  load_val;
    logic [3:0]  step_val;
`ifdef CNT_AUTORELOAD_EN
    logic        term_pulse;
`endif

    // Two-flop synchronizer plus previous-value register; an event is a 1->0 edge.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sync1_q <= '1;
            sync2_q <= '1;
            prev_q  <= '1;
        end else begin
            sync1_q <= {clr_n_i, stop_n_i, start_n_i};
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign evt      = ~sync2_q & prev_q;
    assign ev_start = evt[0];
    assign ev_stop  = evt[1];
    assign ev_clr   = evt[2];

    assign tick     = (state_q == StRun) && (presc_q == PresMax);
    assign load_val = dir_i ? 4'd0 : limit_i;
    assign at_term  = dir_i ? (count_q == limit_i) : (count_q == 4'd0);
    assign step_val = dir_i ? count_q + 4'd1 : count_q - 4'd1;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        presc_d = presc_q;
`ifdef CNT_AUTORELOAD_EN
        term_pulse = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                if (ev_clr) begin
                    count_d = 4'd0;
                end else if (!ev_stop && ev_start) begin
                    state_d = StRun;
                    count_d = load_val;
                    presc_d = '0;
                end
            end
            StRun: begin
                if (ev_clr) begin
                    state_d = StIdle;
                    count_d = 4'd0;
                end else if (ev_stop) begin
                    // Prescaler holds, so a stop on the tick cycle ticks on resume.
                    state_d = StPause;
                end else begin
                    presc_d = tick ? '0 : presc_q + 26'd1;
                    if (tick) begin
                        if (at_term) begin
`ifdef CNT_AUTORELOAD_EN
                            count_d    = load_val;
                            term_pulse = 1'b1;
`else
                            state_d    = StDone;
`endif
                        end else begin
                            count_d = step_val;
                        end
                    end
                end
            end
            StPause: begin
                if (ev_clr) begin
                    state_d = StIdle;
                    count_d = 4'd0;
                end else if (!ev_stop && ev_start) begin
                    state_d = StRun;
                end
            end
            default: begin  // StDone
                if (ev_clr) begin
                    state_d = StIdle;
                    count_d = 4'd0;
                end else if (!ev_stop && ev_start) begin
                    state_d = StRun;
                    count_d = load_val;
                    presc_d = '0;
                end
            end
        endcase

        running_d = (state_d == StRun);
`ifdef CNT_AUTORELOAD_EN
        done_d = term_pulse;
`else
        done_d = (state_d == StDone);
`endif
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            count_q   <= 4'd0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            count_q   <= count_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        hex_o = 7'b1111111;
        case (count_q)
            4'h0: hex_o = 7'b1000000;
            4'h1: hex_o = 7'b1111001;
            4'h2: hex_o = 7'b0100100;
            4'h3: hex_o = 7'b0110000;
            4'h4: hex_o = 7'b0011001;
            4'h5: hex_o = 7'b0010010;
            4'h6: hex_o = 7'b0000010;
            4'h7: hex_o = 7'b1111000;
            4'h8: hex_o = 7'b0000000;
            4'h9: hex_o = 7'b0010000;
            4'hA: hex_o = 7'b0001000;
            4'hB: hex_o = 7'b0000011;
            4'hC: hex_o = 7'b1000110;
            4'hD: hex_o = 7'b0100001;
            4'hE: hex_o = 7'b0000110;
            default: hex_o = 7'b0001110;
        endcase
    end

    assign count_o   = count_q;
    assign running_o = running_q;
    assign done_o    = done_q;

endmodule

// File: tb/tb_count_seq_ctrl.sv
// Bench for count_seq_ctrl: a cycle-level reference model pushes the expected
// outputs after every clock edge; a monitor pops and compares on the falling edge.
module tb_count_seq_ctrl;

    localparam int P = 4;
    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_PAUSE = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_n = 1'b1;
    logic       stop_n = 1'b1;
    logic       clr_n = 1'b1;
    logic       dir = 1'b1;
    logic [3:0] limit = 4'd9;
    logic [3:0] count;
    logic [6:0] hex;
    logic       running;
    logic       done;

    count_seq_ctrl #(.PRESCALE(P)) dut (
        .clk_i     (clk),
        .rst_i     (rst),
        .start_n_i (start_n),
        .stop_n_i  (stop_n),
        .clr_n_i   (clr_n),
        .dir_i     (dir),
        .limit_i   (limit),
        .count_o   (count),
        .hex_o     (hex),
        .running_o (running),
        .done_o    (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0] count;
        logic [6:0] hex;
        logic       running;
        logic       done;
    } exp_t;

    exp_t sb_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    logic [6:0] seg [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                             7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                             7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                             7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference model state. Button history: levels seen at the last three edges
    // since reset, bit order {clr, stop, start}.
    int       m_mode = M_IDLE;
    int       m_count = 0;
    int       m_rc = 0;      // RUN cycles that advanced the prescaler since load
    bit       m_done = 1'b0;
    bit [2:0] h1 = '1, h2 = '1, h3 = '1;

    task automatic model_edge();
        bit [2:0] ev;
        bit       tick, term;
        int       lim;
        exp_t     e;
        m_done = 1'b0;
        if (rst) begin
            m_mode = M_IDLE; m_count = 0; m_rc = 0;
            h1 = '1; h2 = '1; h3 = '1;
        end else begin
            // A press acts two edges after it is first sampled.
            ev = ~h2 & h3;
            h3 = h2; h2 = h1; h1 = {clr_n, stop_n, start_n};
            lim = int'(limit);
            if (ev[2]) begin
                if (m_mode != M_IDLE || m_count != 0) begin
                    m_mode = M_IDLE; m_count = 0;
                end
            end else if (ev[1]) begin
                if (m_mode == M_RUN) m_mode = M_PAUSE;
            end else begin
                if (ev[0] && (m_mode == M_IDLE || m_mode == M_DONE)) begin
                    m_mode = M_RUN; m_rc = 0; m_count = dir ? 0 : lim;
                end else if (ev[0] && m_mode == M_PAUSE) begin
                    m_mode = M_RUN;
                end else if (m_mode == M_RUN) begin
                    tick = (m_rc % P) == P - 1;
                    m_rc++;
                    if (tick) begin
                        term = dir ? (m_count == lim) : (m_count == 0);
                        if (term) begin
`ifdef CNT_AUTORELOAD_EN
                            m_count = dir ? 0 : lim;
                            m_done = 1'b1;
`else
                            m_mode = M_DONE;
`endif
                        end else begin
                            m_count = (m_count + (dir ? 1 : 15)) % 16;
                        end
                    end
                end
            end
`ifndef CNT_AUTORELOAD_EN
            m_done = (m_mode == M_DONE);
`endif
        end
        e.count   = 4'(m_count);
        e.hex     = seg[m_count];
        e.running = (m_mode == M_RUN);
        e.done    = m_done;
        sb_q.push_back(e);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    // 0 = start, 1 = stop, 2 = clr
    task automatic press(input int which, input int hold);
        if (which == 0) start_n = 1'b0;
        else if (which == 1) stop_n = 1'b0;
        else clr_n = 1'b0;
        repeat (hold) cyc();
        start_n = 1'b1; stop_n = 1'b1; clr_n = 1'b1;
    endtask

    task automatic run_until(input int val);
        int k = 0;
        while (!(m_mode == M_RUN && m_count == val) && k < 200) begin
            cyc();
            k++;
        end
        n_cmp++;
        if (k >= 200) begin
            n_bad++;
            $display("FAIL run_until: count %0d not reached in 200 cycles, model at %0d",
                     val, m_count);
        end
    endtask

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, req);
        end
    endtask

    always @(negedge clk) begin : monitor
        exp_t e;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("count", int'(count), int'(e.count));
            check("hex", int'(hex), int'(e.hex));
            check("running", int'(running), int'(e.running));
            check("done", int'(done), int'(e.done));
        end
    end

    initial begin
        @(negedge clk);
        // Reset with buttons released
        rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        cyc();

        // Count up to 9
        dir = 1'b1; limit = 4'd9;
        press(0, 2);
        repeat (50) cyc();

        // Count down from 5
        press(2, 1);
        repeat (4) cyc();
        dir = 1'b0; limit = 4'd5;
        press(0, 3);
        repeat (40) cyc();

        // Pause at 3, hold, then resume
        press(2, 1);
        repeat (4) cyc();
        dir = 1'b1; limit = 4'd15;
        press(0, 1);
        run_until(3);
        press(1, 2);
        repeat (40) cyc();
        press(0, 2);
        repeat (10) cyc();

        // Simultaneous stop and clr at 7
        run_until(7);
        stop_n = 1'b0; clr_n = 1'b0;
        repeat (3) cyc();
        stop_n = 1'b1; clr_n = 1'b1;
        repeat (4) cyc();

        // Reset mid-run at 6
        press(0, 1);
        run_until(6);
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        repeat (10) cyc();

        // Full sweep 0..15 up to the terminal
        press(0, 1);
        repeat (80) cyc();

        // Start held through reset release
        start_n = 1'b0; rst = 1'b1;
        repeat (2) cyc();
        rst = 1'b0;
        repeat (8) cyc();
        start_n = 1'b1;
        repeat (10) cyc();

        // Randomized commands, direction and limit changes, occasional reset
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 15) == 0) start_n = ~start_n;
            if ($urandom_range(0, 29) == 0) stop_n = ~stop_n;
            if ($urandom_range(0, 59) == 0) clr_n = ~clr_n;
            if ($urandom_range(0, 79) == 0) dir = ~dir;
            if ($urandom_range(0, 79) == 0) limit = 4'($urandom_range(0, 15));
            rst = ($urandom_range(0, 499) == 0);
            cyc();
        end
        rst = 1'b0;
        start_n = 1'b1; stop_n = 1'b1; clr_n = 1'b1;
        repeat (5) cyc();

        repeat (2) @(negedge clk);
        check("scoreboard_drained", sb_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/count_seq_ctrl.md
# count_seq_ctrl

Sequencing controller for the 4-bit ripple-style counter datapath on the DE1 board. It turns pushbutton commands into a start/pause/clear state machine and applies a prescaled count-enable tick. It counts up or down between 0 and a switch-selected limit, and drives the counter value plus active-low 7-segment segments for HEX0. It sits between the board keys/switches and the display, replacing free-running manual clocking of the counter.

## Interface
- PRESCALE, 50_000_000, clk cycles per count tick (≥1; 26-bit internal prescaler)
- clk  input  1  system clock (50 MHz on DE1)
- rst  input  1  reset, synchronous, active-high
- start_n  input  1  start/resume pushbutton, active-low, asynchronous to clk
- stop_n  input  1  pause pushbutton, active-low, asynchronous
- clr_n  input  1  clear pushbutton, active-low, asynchronous
- dir  input  1  1 = count up, 0 = count down (switch level)
- limit  input  4  terminal value
- count  output  4  current counter value
- hex  output  7  segments {g,f,e,d,c,b,a}, active-low
- running  output  1  high in RUN
- done  output  1  terminal indication (see Configuration)

## Operation
- Each button passes through a 2-flop synchronizer and a previous-value register, all reset to 1. A command event occurs when the synchronized value is 0 and the previous value is 1. Holding a button produces one event.
- Event priority: clr > stop > start > tick.
- States:
  - IDLE:
    - start → RUN; load count (up: 0, down: limit); prescaler cleared.
    - Otherwise count holds.
  - RUN:
    - clr → IDLE, count 0.
    - stop → PAUSE.
    - Otherwise on tick, count steps ±1 per dir.
  - PAUSE:
    - count and prescaler hold.
    - start → RUN (prescaler resumes from its held value).
    - clr → IDLE, count 0.
  - DONE (only when autoreload is compiled out):
    - count holds at the terminal value.
    - start → RUN with the same load rule as IDLE.
    - clr → IDLE, count 0.
- Tick: the prescaler increments only in RUN. Tick is high when prescaler = PRESCALE-1, and the prescaler then returns to 0. The period is exactly PRESCALE cycles; PRESCALE=1 gives a tick every RUN cycle.
- Terminal event: tick while count equals the terminal (up: limit, down: 0). The terminal event replaces the step.
- Non-terminal steps wrap mod 16. If dir or limit changes mid-run:
  - It takes effect at the next tick.
  - Up with count > limit counts to 15, wraps to 0, then reaches limit.
- hex is combinational from count: 0→1000000, 1→1111001, 2→0100100, 3→0110000, 4→0011001, 5→0010010, 6→0000010, 7→1111000, 8→0000000, 9→0010000, A→0001000, b→0000011, C→1000110, d→0100001, E→0000110, F→0001110.

## Timing
- Reset (rst high at a clk edge): state IDLE, count 0, prescaler 0, sync/prev regs 1, running 0, done 0, hex 1000000. rst overrides all events.
- Button latency: a low level first sampled at edge N → state/count change visible after edge N+2.
- running and done are registered and change on the same edge as the state.
- Stop and tick in the same cycle: stop wins; no step, and the prescaler holds at PRESCALE-1. The first cycle after resume ticks.
- A button held low through reset release produces one event two edges after the first post-reset sample.

## Configuration
- CNT_AUTORELOAD_EN defined:
  - On a terminal event, count reloads (up: 0, down: limit) and stays in RUN.
  - done is a 1-cycle pulse on that edge.
  - DONE state is unused.
- CNT_AUTORELOAD_EN undefined:
  - A terminal event moves the FSM to DONE with running 0.
  - done is held high while in DONE and clears on leaving DONE.

## Test plan
- Reset: rst high 2 cycles with buttons released → count 0, hex 1000000, running 0, done 0.
- PRESCALE=4, macro off, dir=1, limit=9, start pulse:
  - running rises 2 edges after sampling.
  - count steps 0..9, one step per 4 cycles.
  - Next tick → DONE, done=1, count 9, hex 0010000.
- PRESCALE=4, macro on, dir=0, limit=5, start:
  - count 5,4,3,2,1,0 → reload to 5 with a 1-cycle done pulse, running stays 1.
- Pause: stop at count 3, wait 40 cycles → count stays 3. Start → steps to 4 after the remaining prescale cycles.
- Simultaneous stop_n and clr_n falling in RUN at count 7 → IDLE, count 0, hex 1000000.
- Reset mid-run at count 6, buttons released → next edge IDLE, count 0. No tick or start occurs afterwards.
